// File: rtl/gray_window_3x3.sv
// Streaming 3x3 neighbourhood generator: two line buffers feed a shifting 3x3 pixel window.
// Optional GRAY_WIN_SUM_EN adds a registered window sum and one extra aligned output stage.
module gray_window_3x3 #(
    parameter int unsigned IMG_WIDTH = 640,
    parameter int unsigned PIX_W     = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    input  logic                 in_sof,
    input  logic [PIX_W-1:0]     in_pix,
    output logic                 win_valid,
    output logic [9*PIX_W-1:0]   win
`ifdef GRAY_WIN_SUM_EN
    ,
    output logic [PIX_W+3:0]     win_sum
`endif
);

    localparam int unsigned WIN_W = 9 * PIX_W;
    localparam int unsigned SUM_W = PIX_W + 4;
    localparam int unsigned COL_W = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;

    logic [COL_W-1:0] col_q;
    logic [COL_W-1:0] eff_col_c;
    logic [1:0]       row_q;
    logic [1:0]       eff_row_c;
    logic [PIX_W-1:0] lb_top [IMG_WIDTH];
    logic [PIX_W-1:0] lb_mid [IMG_WIDTH];
    logic [PIX_W-1:0] top_c;
    logic [PIX_W-1:0] mid_c;
    logic [WIN_W-1:0] shift_q;
    logic [WIN_W-1:0] shift_c;
    logic             emit_c;
    logic             s1_valid_q;
    logic [WIN_W-1:0] s1_win_q;

    // A start-of-frame pixel is treated as row 0, col 0 regardless of counter state.
    always_comb begin
        eff_col_c = in_sof ? '0 : col_q;
        eff_row_c = in_sof ? '0 : row_q;
        top_c     = lb_top[eff_col_c];
        mid_c     = lb_mid[eff_col_c];
        emit_c    = in_valid && (eff_row_c == 2'd2) && (eff_col_c >= COL_W'(2));
    end

    // Next window: drop column 0, shift columns left, insert {top, mid, new pixel} as column 2.
    always_comb begin
        shift_c = shift_q;
        for (int r = 0; r < 3; r++) begin
            shift_c[PIX_W*(3*r)   +: PIX_W] = shift_q[PIX_W*(3*r+1) +: PIX_W];
            shift_c[PIX_W*(3*r+1) +: PIX_W] = shift_q[PIX_W*(3*r+2) +: PIX_W];
        end
        shift_c[PIX_W*2 +: PIX_W] = top_c;
        shift_c[PIX_W*5 +: PIX_W] = mid_c;
        shift_c[PIX_W*8 +: PIX_W] = in_pix;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            col_q <= '0;
            row_q <= '0;
        end else if (in_valid) begin
            if (eff_col_c == COL_W'(IMG_WIDTH - 1)) begin
                col_q <= '0;
                row_q <= (eff_row_c == 2'd2) ? eff_row_c : eff_row_c + 2'd1;
            end else begin
                col_q <= eff_col_c + COL_W'(1);
                row_q <= eff_row_c;
            end
        end
    end

    // Line buffers are never cleared; emission gating hides stale contents.
    always_ff @(posedge clk) begin
        if (!reset && in_valid) begin
            lb_top[eff_col_c] <= mid_c;
            lb_mid[eff_col_c] <= in_pix;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            shift_q    <= '0;
            s1_valid_q <= 1'b0;
            s1_win_q   <= '0;
        end else begin
            s1_valid_q <= emit_c;
            if (in_valid) begin
                shift_q <= shift_c;
            end
            if (emit_c) begin
                s1_win_q <= shift_c;
            end
        end
    end

`ifdef GRAY_WIN_SUM_EN
    logic [SUM_W-1:0] sum_c;

    always_comb begin
        sum_c = '0;
        for (int i = 0; i < 9; i++) begin
            sum_c = sum_c + SUM_W'(s1_win_q[PIX_W*i +: PIX_W]);
        end
    end

    // Second stage keeps win, win_valid and win_sum aligned.
    always_ff @(posedge clk) begin
        if (reset) begin
            win_valid <= 1'b0;
            win       <= '0;
            win_sum   <= '0;
        end else begin
            win_valid <= s1_valid_q;
            if (s1_valid_q) begin
                win     <= s1_win_q;
                win_sum <= sum_c;
            end
        end
    end
`else
    assign win_valid = s1_valid_q;
    assign win       = s1_win_q;
`endif

endmodule

// File: tb/tb_gray_window_3x3.sv
// Scoreboard bench for gray_window_3x3 at IMG_WIDTH=8; handles both GRAY_WIN_SUM_EN builds.
module tb_gray_window_3x3;

    localparam int unsigned W  = 8;
    localparam int unsigned PW = 8;
`ifdef GRAY_WIN_SUM_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    typedef struct {
        logic [71:0] w;
        logic [11:0] sum;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_sof;
    logic [7:0]  in_pix;
    logic        win_valid;
    logic [71:0] win;
`ifdef GRAY_WIN_SUM_EN
    logic [11:0] win_sum;
`endif

    gray_window_3x3 #(.IMG_WIDTH(W), .PIX_W(PW)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_sof    (in_sof),
        .in_pix    (in_pix),
        .win_valid (win_valid),
`ifdef GRAY_WIN_SUM_EN
        .win_sum   (win_sum),
`endif
        .win       (win)
    );

    always #5 clk = ~clk;

    int          cyc = 0;
    int          n_checks = 0;
    int          n_pass = 0;
    int          win_cnt = 0;
    logic        got_first = 1'b0;
    logic [71:0] first_win = '0;
    logic [71:0] last_win = '0;
    logic [11:0] last_sum = '0;
    exp_t        exp_q[$];
    exp_t        m_e;

    logic [7:0]  img [16][8];
    int          fr = 0;
    int          fc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [7:0] pat(input int lin);
        return 8'(16 * (lin / 8) + (lin % 8));
    endfunction

    // Reference: frame-coordinate image, window taken straight from the stored pixels.
    task automatic model_accept(input logic s, input logic [7:0] p);
        exp_t e;
        if (s) begin
            fr = 0;
            fc = 0;
        end
        img[fr][fc] = p;
        if (fr >= 2 && fc >= 2) begin
            e.sum = '0;
            e.w   = '0;
            for (int r = 0; r < 3; r++)
                for (int c = 0; c < 3; c++) begin
                    e.w[8*(3*r+c) +: 8] = img[fr-2+r][fc-2+c];
                    e.sum = e.sum + 12'(img[fr-2+r][fc-2+c]);
                end
            e.cyc = cyc + 1;
            exp_q.push_back(e);
        end
        fc++;
        if (fc == 8) begin
            fc = 0;
            if (fr < 15) fr++;
        end
    endtask

    task automatic drive(input logic v, input logic s, input logic [7:0] p);
        in_valid = v;
        in_sof   = s;
        in_pix   = p;
        if (v) model_accept(s, p);
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 8'h5A);
    endtask

    task automatic start_scn;
        win_cnt   = 0;
        got_first = 1'b0;
    endtask

    // Monitor: pops one expectation per presented window and checks content and timing.
    always @(negedge clk) begin
        if (!reset && win_valid) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_window: got win %0h at cycle %0d, expected none", win, cyc);
            end else begin
                m_e = exp_q.pop_front();
                chk("win_content", 128'(win), 128'(m_e.w));
                chk("win_latency", 128'(cyc), 128'(m_e.cyc + LAT - 1));
`ifdef GRAY_WIN_SUM_EN
                chk("win_sum", 128'(win_sum), 128'(m_e.sum));
                last_sum = win_sum;
`endif
            end
            win_cnt++;
            if (!got_first) begin
                first_win = win;
                got_first = 1'b1;
            end
            last_win = win;
        end
    end

    initial begin
        reset    = 1'b1;
        in_valid = 1'b0;
        in_sof   = 1'b0;
        in_pix   = '0;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        chk("reset_win_valid", 128'(win_valid), 128'(0));
        chk("reset_win", 128'(win), 128'(0));
`ifdef GRAY_WIN_SUM_EN
        chk("reset_win_sum", 128'(win_sum), 128'(0));
`endif
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Full 4-row frame, continuous input.
        start_scn();
        for (int i = 0; i < 32; i++) drive(1'b1, i == 0, pat(i));
        drain(4);
        chk("s1_count", 128'(win_cnt), 128'(12));
        chk("s1_first_p00", 128'(first_win[0 +: 8]), 128'(8'h00));
        chk("s1_first_p11", 128'(first_win[32 +: 8]), 128'(8'h11));
        chk("s1_first_p22", 128'(first_win[64 +: 8]), 128'(8'h22));
        chk("s1_last_p22", 128'(last_win[64 +: 8]), 128'(8'h37));

        // Same frame with in_valid toggling.
        start_scn();
        for (int i = 0; i < 32; i++) begin
            drive(1'b1, i == 0, pat(i));
            drive(1'b0, 1'b0, 8'hAA);
        end
        drain(4);
        chk("s2_count", 128'(win_cnt), 128'(12));
        chk("s2_first_p22", 128'(first_win[64 +: 8]), 128'(8'h22));
        chk("s2_last_p22", 128'(last_win[64 +: 8]), 128'(8'h37));

        // 10-row frame: row saturation and column wrap.
        start_scn();
        for (int i = 0; i < 80; i++) drive(1'b1, i == 0, pat(i));
        drain(4);
        chk("s3_count", 128'(win_cnt), 128'(48));
        chk("s3_last_p22", 128'(last_win[64 +: 8]), 128'(8'h97));

        // in_sof arriving at row 3 col 4 restarts the frame.
        start_scn();
        for (int i = 0; i < 28; i++) drive(1'b1, i == 0, pat(i));
        drain(4);
        chk("s4_pre_count", 128'(win_cnt), 128'(8));
        start_scn();
        for (int k = 0; k < 18; k++) drive(1'b1, k == 0, pat(28 + k));
        drain(4);
        chk("s4_quiet_count", 128'(win_cnt), 128'(0));
        for (int k = 18; k < 24; k++) drive(1'b1, 1'b0, pat(28 + k));
        drain(4);
        chk("s4_count", 128'(win_cnt), 128'(6));
        chk("s4_first_p22", 128'(first_win[64 +: 8]), 128'(8'h56));

        // Reset pulsed at row 2 col 5, then a fresh frame without in_sof.
        start_scn();
        for (int i = 0; i < 21; i++) drive(1'b1, i == 0, pat(i));
        drain(4);
        chk("s5_pre_count", 128'(win_cnt), 128'(3));
        chk("s5_pre_queue", 128'(exp_q.size()), 128'(0));
        reset    = 1'b1;
        in_valid = 1'b1;
        in_sof   = 1'b0;
        in_pix   = pat(21);
        @(posedge clk);
        #1;
        reset    = 1'b0;
        in_valid = 1'b0;
        fr = 0;
        fc = 0;
        @(negedge clk);
        chk("s5_rst_win_valid", 128'(win_valid), 128'(0));
        chk("s5_rst_win", 128'(win), 128'(0));
        @(posedge clk);
        #1;
        start_scn();
        for (int i = 0; i < 24; i++) drive(1'b1, 1'b0, pat(i));
        drain(4);
        chk("s5_count", 128'(win_cnt), 128'(6));
        chk("s5_first_p22", 128'(first_win[64 +: 8]), 128'(8'h22));

        // Constant frames: all 0xFF then all 0x01.
        start_scn();
        for (int i = 0; i < 24; i++) drive(1'b1, i == 0, 8'hFF);
        drain(4);
        chk("s6_ff_count", 128'(win_cnt), 128'(6));
        chk("s6_ff_win", 128'(last_win), 128'({9{8'hFF}}));
`ifdef GRAY_WIN_SUM_EN
        chk("s6_ff_sum", 128'(last_sum), 128'(12'h8F7));
`endif
        start_scn();
        for (int i = 0; i < 24; i++) drive(1'b1, i == 0, 8'h01);
        drain(4);
        chk("s6_01_count", 128'(win_cnt), 128'(6));
`ifdef GRAY_WIN_SUM_EN
        chk("s6_01_sum", 128'(last_sum), 128'(9));
`endif

        chk("final_queue_empty", 128'(exp_q.size()), 128'(0));
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
